// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and framing constants for the UART TX drain
package uart_pkg;
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} uart_tx_state_t;
  localparam int UART_DATA_W = 8;
  localparam int UART_STOP_BITS = 1;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, tick marks the last cycle of each bit
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && (cnt_q == W'(CLKS_PER_BIT - 1));
  // next count: restart on state entry or bit boundary, otherwise advance while enabled
  always_comb cnt_d = (clear || tick) ? '0 : en ? cnt_q + W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops one byte per frame from a FIFO and sends it as 8N1 UART
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_en,
  output logic              tx,
  output logic              busy
);
  uart_tx_state_t state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0] bit_q, bit_d;
  logic tx_q, tx_d;
  logic tick, baud_en, baud_clear;
  assign baud_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign baud_clear = state_d != state_q;
  assign fifo_read_en = state_q == POP;
  assign busy = state_q != IDLE;
  assign tx = tx_q;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .en   (baud_en),
    .tick (tick)
  );
  // frame sequencing; tx is derived from the next state so it changes with the state
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d = bit_q;
    unique case (state_q)
      IDLE:  state_d = fifo_empty ? IDLE : POP;
      POP:   state_d = LATCH;
      LATCH: begin
        shreg_d = fifo_data;
        state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA:  if (tick) begin
        shreg_d = shreg_q >> 1;
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'(DATA_W - 1)) ? STOP : DATA;
      end
      STOP:  state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
  end
  // state, shift register, bit counter and line register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: directed scenarios for the FIFO-draining UART transmitter
module tb_uart_tx_drain;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold_empty = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic fifo_empty, fifo_read_en, tx, busy;
  logic [7:0] mem [0:63];
  int rd_ptr = 0, wr_ptr = 0, cyc = 0, pops = 0, last_pop = -1;
  int busy_rise = -1, busy_fall = -1;
  logic prev_busy = 1'b0;
  int n_cmp = 0, n_bad = 0;

  assign fifo_empty = hold_empty || (rd_ptr == wr_ptr);

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_en(fifo_read_en),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // FIFO read port model: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_en) begin
      fifo_data <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // pop and busy edge bookkeeping
  always @(negedge clk) begin
    if (fifo_read_en) begin
      pops <= pops + 1;
      last_pop <= cyc;
    end
    if (busy && !prev_busy) busy_rise <= cyc;
    if (!busy && prev_busy) busy_fall <= cyc;
    prev_busy <= busy;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  task automatic wait_start(output int s, output bit ok);
    ok = 1'b0;
    s = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        s = cyc;
        break;
      end
    end
  endtask

  task automatic capture_frame(output logic [39:0] v, output int s, output bit ok);
    v = '0;
    wait_start(s, ok);
    if (ok) begin
      v[0] = tx;
      for (int i = 1; i < 40; i++) begin
        @(negedge clk);
        v[i] = tx;
      end
    end
  endtask

  function automatic logic [7:0] dec(input logic [39:0] v);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = v[4 * (k + 1) + 2];
    return b;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    logic [39:0] v;
    int s, r;
    bit ok;
    push(8'h3C);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({tx, fifo_read_en, busy} !== 3'b100) begin
        n_bad++;
        $display("FAIL reset_outputs: tx/rd/busy=%b want 100", {tx, fifo_read_en, busy});
      end
    end
    rst_n = 1'b1;
    r = cyc;
    @(negedge clk);
    n_cmp++;
    if (fifo_read_en !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_pop: read_en=%b want 1", fifo_read_en);
    end
    capture_frame(v, s, ok);
    n_cmp++;
    if (!ok || s != r + 3) begin
      n_bad++;
      $display("FAIL reset_start_cycle: got %0d want %0d", s, r + 3);
    end
    n_cmp++;
    if (dec(v) !== 8'h3C) begin
      n_bad++;
      $display("FAIL reset_byte: got %h want 3c", dec(v));
    end
    wait_idle();
  endtask

  task automatic test_single();
    logic [39:0] v, exp_v;
    logic [9:0] seq;
    int s, n, p0;
    bit ok;
    seq = 10'b11_0100_1010;
    for (int i = 0; i < 40; i++) exp_v[i] = seq[i / 4];
    repeat (3) @(negedge clk);
    p0 = pops;
    push(8'hA5);
    n = cyc;
    capture_frame(v, s, ok);
    n_cmp++;
    if (!ok || s != n + 3) begin
      n_bad++;
      $display("FAIL single_latency: start %0d want %0d", s, n + 3);
    end
    n_cmp++;
    if (v !== exp_v) begin
      n_bad++;
      $display("FAIL single_wave: got %h want %h", v, exp_v);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pops - p0 != 1) begin
      n_bad++;
      $display("FAIL single_pops: got %0d want 1", pops - p0);
    end
    n_cmp++;
    if (busy_rise != n + 1 || busy_fall != n + 43) begin
      n_bad++;
      $display("FAIL single_busy: rise %0d fall %0d want %0d %0d", busy_rise, busy_fall, n + 1, n + 43);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] v;
    int s, prev_s, p0;
    bit ok;
    @(negedge clk);
    p0 = pops;
    prev_s = 0;
    for (int b = 0; b < 5; b++) push(8'(b));
    for (int k = 0; k < 5; k++) begin
      capture_frame(v, s, ok);
      n_cmp++;
      if (!ok || dec(v) !== 8'(k)) begin
        n_bad++;
        $display("FAIL b2b_byte%0d: got %h ok=%0d want %h", k, dec(v), ok, 8'(k));
      end
      if (k > 0) begin
        n_cmp++;
        if (s - prev_s != 43) begin
          n_bad++;
          $display("FAIL b2b_period%0d: got %0d want 43", k, s - prev_s);
        end
      end
      prev_s = s;
    end
    wait_idle();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pops - p0 != 5) begin
      n_bad++;
      $display("FAIL b2b_pops: got %0d want 5", pops - p0);
    end
  endtask

  task automatic test_empty();
    int p0, bad_tx, bad_busy;
    bad_tx = 0;
    bad_busy = 0;
    @(negedge clk);
    p0 = pops;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    @(negedge clk);
    n_cmp++;
    if (pops != p0) begin
      n_bad++;
      $display("FAIL empty_pops: got %0d want 0", pops - p0);
    end
    n_cmp++;
    if (bad_tx != 0) begin
      n_bad++;
      $display("FAIL empty_tx: %0d cycles low want 0", bad_tx);
    end
    n_cmp++;
    if (bad_busy != 0) begin
      n_bad++;
      $display("FAIL empty_busy: %0d cycles busy want 0", bad_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] v;
    int s, s2, r, p0;
    bit ok;
    @(negedge clk);
    push(8'h5A);
    wait_start(s, ok);
    repeat (13) @(negedge clk);
    n_cmp++;
    if (!ok || tx !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_bit2: tx=%b want 0", tx);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_bit3: tx/busy=%b%b want 11", tx, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx, fifo_read_en, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL mid_async: tx/rd/busy=%b want 100", {tx, fifo_read_en, busy});
    end
    push(8'h81);
    p0 = pops;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (pops != p0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_hold: pops %0d busy %b want 0 0", pops - p0, busy);
    end
    rst_n = 1'b1;
    r = cyc;
    capture_frame(v, s2, ok);
    n_cmp++;
    if (!ok || s2 != r + 3) begin
      n_bad++;
      $display("FAIL mid_restart: start %0d want %0d", s2, r + 3);
    end
    n_cmp++;
    if (dec(v) !== 8'h81) begin
      n_bad++;
      $display("FAIL mid_byte: got %h want 81", dec(v));
    end
    wait_idle();
    n_cmp++;
    if (last_pop != r + 1) begin
      n_bad++;
      $display("FAIL mid_pop_cycle: got %0d want %0d", last_pop, r + 1);
    end
  endtask

  task automatic test_empty_during_stop();
    logic [39:0] v;
    int s, s2, n, p0, bad_tx, bad_rd, bad_busy;
    bit ok;
    bad_tx = 0;
    bad_rd = 0;
    bad_busy = 0;
    @(negedge clk);
    p0 = pops;
    push(8'hC3);
    push(8'hE7);
    wait_start(s, ok);
    repeat (37) @(negedge clk);
    hold_empty = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (fifo_read_en !== 1'b0) bad_rd++;
      if (cyc >= s + 40 && busy !== 1'b0) bad_busy++;
    end
    n_cmp++;
    if (!ok || bad_tx != 0 || bad_rd != 0 || bad_busy != 0) begin
      n_bad++;
      $display("FAIL stop_empty: tx %0d rd %0d busy %0d bad cycles want 0", bad_tx, bad_rd, bad_busy);
    end
    n_cmp++;
    if (pops - p0 != 1) begin
      n_bad++;
      $display("FAIL stop_empty_pops: got %0d want 1", pops - p0);
    end
    hold_empty = 1'b0;
    n = cyc;
    capture_frame(v, s2, ok);
    n_cmp++;
    if (!ok || s2 != n + 3 || dec(v) !== 8'hE7) begin
      n_bad++;
      $display("FAIL stop_resume: start %0d byte %h want %0d e7", s2, dec(v), n + 3);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_reset_mid();
    test_empty_during_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
